// File: rtl/instr_fetch_queue_if.sv
// Fetch/IMEM/decode bus bundle for instr_fetch_queue.
// Latency: none, because this is wiring only.
// Backpressure: Instr_Valid/Instr_Ready toward decode, and Branch_Valid redirects fetch.
interface instr_fetch_queue_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 10
);
    logic                     Branch_Valid;
    logic [ADDR_WIDTH-1:0]    Branch_PC;
    logic [ADDR_WIDTH-1:0]    PC_Immed;
    logic [MEM_ADDR_BITS-1:0] Imem_Addr;
    logic [31:0]              Imem_Dout;
    logic [31:0]              Instr;
    logic [ADDR_WIDTH-1:0]    Instr_PC;
    logic                     Instr_Valid;
    logic                     Instr_Ready;

    // Fetch unit side
    modport master (
        input  Branch_Valid, Branch_PC, PC_Immed, Imem_Dout, Instr_Ready,
        output Imem_Addr, Instr, Instr_PC, Instr_Valid
    );

    // Environment side (IMEM, decode, branch unit)
    modport slave (
        output Branch_Valid, Branch_PC, PC_Immed, Imem_Dout, Instr_Ready,
        input  Imem_Addr, Instr, Instr_PC, Instr_Valid
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Decoupled fetch: owns the PC, issues IMEM word reads and buffers results in a prefetch queue.
// Latency: issue to Instr_Valid is 2 cycles, and a redirect target becomes visible 3 cycles after Branch_Valid.
// Backpressure: Instr_Ready low fills the queue, and issue stops when count+inflight reaches QUEUE_DEPTH.
// Optional: IF_PERF_COUNTERS_EN adds the Stall_Cycles/Flush_Count saturating counters.
module instr_fetch_queue #(
    parameter int                  ADDR_WIDTH    = 32,
    parameter int                  MEM_ADDR_BITS = 10,
    parameter int                  QUEUE_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    instr_fetch_queue_if.master    bus
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0]            Stall_Cycles,
    output logic [31:0]            Flush_Count
`endif
);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [31:0]           q_instr_q [QUEUE_DEPTH];
    logic [31:0]           q_instr_d [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc_q    [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc_d    [QUEUE_DEPTH];

    logic                  instr_valid;
    logic                  do_issue;
    logic                  do_wr;
    logic                  do_deq;
    logic                  has_room;
    logic [ADDR_WIDTH-1:0] redirect_tgt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign instr_valid   = (count_q != '0);
    assign has_room      = (int'(count_q) + int'(inflight_q)) < QUEUE_DEPTH;
    assign do_issue      = has_room && !bus.Branch_Valid;
    // A return landing in a redirect cycle belongs to the wrong path, so it is dropped.
    assign do_wr         = inflight_q && !bus.Branch_Valid;
    // Consumption happens even in a redirect cycle, and the flush then discards the remainder.
    assign do_deq        = instr_valid && bus.Instr_Ready;
    // The target is relative to the branch's own address plus 4, and it is forced to word alignment.
    assign redirect_tgt  = (bus.Branch_PC + ADDR_WIDTH'(4) + bus.PC_Immed) & ~ADDR_WIDTH'(3);

    assign bus.Imem_Addr   = fetch_pc_q[MEM_ADDR_BITS+1:2];
    assign bus.Instr       = q_instr_q[rd_ptr_q];
    assign bus.Instr_PC    = q_pc_q[rd_ptr_q];
    assign bus.Instr_Valid = instr_valid;

    // Next-state for the PC, the inflight tracker and the queue pointers/storage
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        q_instr_d     = q_instr_q;
        q_pc_d        = q_pc_q;

        if (bus.Branch_Valid) begin
            fetch_pc_d = redirect_tgt;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            inflight_d = do_issue;
            if (do_issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(4);
            end
            if (do_wr) begin
                q_instr_d[wr_ptr_q] = bus.Imem_Dout;
                q_pc_d[wr_ptr_q]    = inflight_pc_q;
                wr_ptr_d            = ptr_inc(wr_ptr_q);
            end
            if (do_deq) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_wr && !do_deq) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_wr && do_deq) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State registers: reset wins over redirect and handshake
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_instr_q[i] <= '0;
                q_pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            q_instr_q     <= q_instr_d;
            q_pc_q        <= q_pc_d;
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Saturating event counters for decode stalls and redirects
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (instr_valid && !bus.Instr_Ready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (bus.Branch_Valid && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign Stall_Cycles = stall_cycles_q;
    assign Flush_Count  = flush_count_q;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a one-cycle IMEM model holding word n = n.
// Latency: this bench checks the 2-cycle fetch latency and the 3-cycle latency from redirect to target.
// Backpressure: this bench drives stalls, redirects with and without a handshake, and a mid-stream reset.
module tb_instr_fetch_queue;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    instr_fetch_queue_if #(.ADDR_WIDTH(32), .MEM_ADDR_BITS(10)) bus ();

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    instr_fetch_queue #(
        .ADDR_WIDTH(32), .MEM_ADDR_BITS(10), .QUEUE_DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
`ifdef IF_PERF_COUNTERS_EN
        ,
        .Stall_Cycles (stall_cycles),
        .Flush_Count  (flush_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous IMEM: word n holds n, and the data is one cycle behind the address
    always @(posedge clk) bus.Imem_Dout <= {22'd0, bus.Imem_Addr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, bus.Instr_Valid}, 32'd1);
        chk({tag, "_pc"}, bus.Instr_PC, pc);
        chk({tag, "_instr"}, bus.Instr, pc >> 2);
    endtask

    initial begin
        logic [31:0] pc;
        checks           = 0;
        failures         = 0;
        clk              = 1'b0;
        rst              = 1'b1;
        bus.Branch_Valid = 1'b0;
        bus.Branch_PC    = '0;
        bus.PC_Immed     = '0;
        bus.Instr_Ready  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, bus.Instr_Valid}, 32'd0);
        chk("rst_instr", bus.Instr, 32'd0);
        chk("rst_pc", bus.Instr_PC, 32'd0);
        chk("rst_imem_addr", {22'd0, bus.Imem_Addr}, 32'd0);
`ifdef IF_PERF_COUNTERS_EN
        chk("rst_stall_cnt", stall_cycles, 32'd0);
        chk("rst_flush_cnt", flush_count, 32'd0);
`endif

        // Release: C0 issues PC 0, and the head appears in C2
        rst             = 1'b0;
        bus.Instr_Ready = 1'b1;
        @(negedge clk);
        chk("c1_valid", {31'd0, bus.Instr_Valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_head("stream", 32'(i * 4));
        end

        // Stall 10 cycles with head PC 12: the queue fills and IMEM address freezes at word 7
        bus.Instr_Ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check_head("stall", 32'd12);
            if (i >= 2) chk("imem_frozen", {22'd0, bus.Imem_Addr}, 32'd7);
        end
`ifdef IF_PERF_COUNTERS_EN
        chk("stall_cnt", stall_cycles, 32'd10);
`endif

        // Resume: PCs must continue 16, 20, ... with no gap or repeat
        bus.Instr_Ready = 1'b1;
        pc = 32'd12;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pc = pc + 32'd4;
            check_head("resume", pc);
        end

        // Redirect without handshake: 0x20 + 4 + 0x10 = 0x34
        bus.Branch_Valid = 1'b1;
        bus.Branch_PC    = 32'h20;
        bus.PC_Immed     = 32'h10;
        bus.Instr_Ready  = 1'b0;
        @(negedge clk);
        bus.Branch_Valid = 1'b0;
        bus.Instr_Ready  = 1'b1;
        chk("br1_flush_valid", {31'd0, bus.Instr_Valid}, 32'd0);
        chk("br1_imem_addr", {22'd0, bus.Imem_Addr}, 32'd13);
        @(negedge clk);
        chk("br1_gap_valid", {31'd0, bus.Instr_Valid}, 32'd0);
        @(negedge clk);
        check_head("br1_target", 32'h34);
        @(negedge clk);
        check_head("br1_next", 32'h38);

        // Redirect together with a handshake on head 0x38: 0x40 + 4 - 8 = 0x3C
        bus.Branch_Valid = 1'b1;
        bus.Branch_PC    = 32'h40;
        bus.PC_Immed     = 32'hFFFF_FFF8;
        bus.Instr_Ready  = 1'b1;
        @(negedge clk);
        bus.Branch_Valid = 1'b0;
        chk("br2_flush_valid", {31'd0, bus.Instr_Valid}, 32'd0);
        chk("br2_imem_addr", {22'd0, bus.Imem_Addr}, 32'd15);
`ifdef IF_PERF_COUNTERS_EN
        chk("flush_cnt", flush_count, 32'd2);
`endif
        @(negedge clk);
        chk("br2_gap_valid", {31'd0, bus.Instr_Valid}, 32'd0);
        @(negedge clk);
        check_head("br2_target", 32'h3C);
        bus.Instr_Ready = 1'b0;
        @(negedge clk);
        check_head("br2_hold", 32'h3C);

        // Mid-stream reset, with a concurrent redirect that reset must override
        rst              = 1'b1;
        bus.Branch_Valid = 1'b1;
        bus.Branch_PC    = 32'h100;
        bus.PC_Immed     = 32'h0;
        @(negedge clk);
        chk("rst2_valid", {31'd0, bus.Instr_Valid}, 32'd0);
        chk("rst2_instr", bus.Instr, 32'd0);
        chk("rst2_pc", bus.Instr_PC, 32'd0);
        chk("rst2_imem_addr", {22'd0, bus.Imem_Addr}, 32'd0);
`ifdef IF_PERF_COUNTERS_EN
        chk("rst2_stall_cnt", stall_cycles, 32'd0);
        chk("rst2_flush_cnt", flush_count, 32'd0);
`endif
        rst              = 1'b0;
        bus.Branch_Valid = 1'b0;
        bus.Instr_Ready  = 1'b1;
        @(negedge clk);
        chk("rst2_c1_valid", {31'd0, bus.Instr_Valid}, 32'd0);
        @(negedge clk);
        check_head("restart0", 32'h0);
        @(negedge clk);
        check_head("restart1", 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
